// File: rtl/cic_decim_ctrl_if.sv
// Sample handshake bundle for the CIC decimation sequencer.
// The slave side is the sequencer: it takes s_valid/m_ready and drives
// s_ready/m_valid. The master side is the sample source/sink.
interface cic_decim_ctrl_if;
  logic s_valid;
  logic s_ready;
  logic m_valid;
  logic m_ready;

  modport master (
    output s_valid,
    output m_ready,
    input  s_ready,
    input  m_valid
  );

  modport slave (
    input  s_valid,
    input  m_ready,
    output s_ready,
    output m_valid
  );
endinterface

// File: rtl/cic_decim_ctrl.sv
// Single-clock sequencer for a CIC decimator. It issues integrator and
// comb enables in place of a divided comb clock, runs the start-up
// clear/settle sequence, holds a one-deep output slot against downstream
// backpressure, supplies the output normalisation shift and keeps a
// sticky overflow flag.
module cic_decim_ctrl #(
  parameter int STAGES          = 1,
  parameter int MAX_RATE_LOG2   = 6,
  parameter int COMB_LAT        = 1,
  localparam int RL_W           = $clog2(MAX_RATE_LOG2 + 1),
  localparam int SH_W           = $clog2(STAGES * MAX_RATE_LOG2 + 1)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                enable,
  input  logic [RL_W-1:0]     cfg_rate_log2,
  cic_decim_ctrl_if.slave     hs,
  output logic                integ_en,
  output logic                comb_en,
  output logic                filt_clr,
  output logic [SH_W-1:0]     out_shift,
  input  logic                ovf_in,
  input  logic                ovf_clr,
  output logic                ovf_sticky,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam int PH_W = MAX_RATE_LOG2;
  localparam int SC_W = (STAGES > 1) ? $clog2(STAGES + 1) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'((STAGES > 0) ? STAGES - 1 : 0);

  // Saturate the requested rate into the supported range [1, MAX_RATE_LOG2].
  function automatic logic [RL_W-1:0] clamp_rate(input logic [RL_W-1:0] r);
    if (r == '0)
      return RL_W'(1);
    else if (int'(r) > MAX_RATE_LOG2)
      return RL_W'(MAX_RATE_LOG2);
    else
      return r;
  endfunction

  // Bit growth of the CIC is STAGES*log2(rate); that is the shift to undo it.
  function automatic logic [SH_W-1:0] shift_for(input logic [RL_W-1:0] r);
    return SH_W'(STAGES * int'(r));
  endfunction

  state_t            state_q;
  state_t            state_d;
  logic [RL_W-1:0]   rate_log2_eff;
  logic [PH_W-1:0]   phase_cnt;
  logic [PH_W-1:0]   last_mask;
  logic [SC_W-1:0]   settle_cnt;
  logic              m_valid_q;
  logic              s_ready_c;
  logic              at_last;
  logic              active;
  logic              flush;
  logic              comb_run;
  logic              pipe_out;
  logic              pipe_busy;

  assign state    = state_q;
  assign active   = (state_q == S_SETTLE) || (state_q == S_RUN);
  assign at_last  = (phase_cnt == last_mask);
  // CLEAR and any disable wipe the in-flight block bookkeeping.
  assign flush    = (state_q == S_CLEAR) || !enable;
  assign filt_clr = (state_q == S_CLEAR);

  // A block boundary may only be accepted when the output slot and the
  // comb pipeline are both empty, so a finished block never overwrites one
  // that downstream has not taken yet.
  assign s_ready_c   = active && !(at_last && (m_valid_q || pipe_busy));
  assign hs.s_ready  = s_ready_c;
  assign hs.m_valid  = m_valid_q;
  assign integ_en    = hs.s_valid && s_ready_c;
  assign comb_en     = integ_en && at_last;
  assign comb_run    = comb_en && (state_q == S_RUN);

  // Wrap value of the phase counter: 2^rate_log2_eff - 1 as a bit mask.
  always_comb begin
    last_mask = '0;
    for (int i = 0; i < PH_W; i++) begin
      if (i < int'(rate_log2_eff))
        last_mask[i] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic: disable dominates, CLEAR lasts one cycle, SETTLE
  // discards STAGES comb outputs before RUN.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_CLEAR;
        S_CLEAR:  state_d = (STAGES > 0) ? S_SETTLE : S_RUN;
        S_SETTLE: begin
          if (comb_en && (settle_cnt == SETTLE_LAST))
            state_d = S_RUN;
        end
        S_RUN:    state_d = S_RUN;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Rate and output shift are latched only when leaving IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rate_log2_eff <= RL_W'(1);
      out_shift     <= SH_W'(STAGES);
    end else if ((state_q == S_IDLE) && enable) begin
      rate_log2_eff <= clamp_rate(cfg_rate_log2);
      out_shift     <= shift_for(clamp_rate(cfg_rate_log2));
    end
  end

  // Phase within the current decimation block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      phase_cnt <= '0;
    else if (flush)
      phase_cnt <= '0;
    else if (integ_en)
      phase_cnt <= at_last ? '0 : phase_cnt + PH_W'(1);
  end

  // Number of comb outputs discarded so far during SETTLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      settle_cnt <= '0;
    else if (flush)
      settle_cnt <= '0;
    else if (comb_en && (state_q == S_SETTLE))
      settle_cnt <= settle_cnt + SC_W'(1);
  end

  // Comb latency tracking: the output slot register itself is the final
  // stage, so COMB_LAT-1 extra valid bits sit in front of it.
  generate
    if (COMB_LAT > 1) begin : g_pipe
      logic [COMB_LAT-2:0] vld_p;

      // Shift a RUN comb strobe towards the output slot.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          vld_p <= '0;
        end else if (flush) begin
          vld_p <= '0;
        end else begin
          for (int i = COMB_LAT - 2; i > 0; i--)
            vld_p[i] <= vld_p[i-1];
          vld_p[0] <= comb_run;
        end
      end

      assign pipe_out  = vld_p[COMB_LAT-2];
      assign pipe_busy = |vld_p;
    end else begin : g_nopipe
      assign pipe_out  = comb_run;
      assign pipe_busy = 1'b0;
    end
  endgenerate

  // Output slot: filled by the comb pipeline, emptied by a downstream transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      m_valid_q <= 1'b0;
    else if (flush)
      m_valid_q <= 1'b0;
    else if (pipe_out)
      m_valid_q <= 1'b1;
    else if (m_valid_q && hs.m_ready)
      m_valid_q <= 1'b0;
  end

  // Sticky overflow: set wins over clear; datapath flags are meaningless
  // outside SETTLE/RUN and are ignored there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      ovf_sticky <= 1'b0;
    else if (state_q == S_CLEAR)
      ovf_sticky <= 1'b0;
    else if (active && ovf_in)
      ovf_sticky <= 1'b1;
    else if (ovf_clr)
      ovf_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// Directed bench for cic_decim_ctrl with STAGES=2, MAX_RATE_LOG2=6, COMB_LAT=1.
module tb_cic_decim_ctrl;

  localparam int STAGES        = 2;
  localparam int MAX_RATE_LOG2 = 6;
  localparam int COMB_LAT      = 1;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic [2:0] cfg_rate_log2;
  logic       integ_en;
  logic       comb_en;
  logic       filt_clr;
  logic [3:0] out_shift;
  logic       ovf_in;
  logic       ovf_clr;
  logic       ovf_sticky;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;

  cic_decim_ctrl_if bus ();

  cic_decim_ctrl #(
    .STAGES        (STAGES),
    .MAX_RATE_LOG2 (MAX_RATE_LOG2),
    .COMB_LAT      (COMB_LAT)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .enable        (enable),
    .cfg_rate_log2 (cfg_rate_log2),
    .hs            (bus.slave),
    .integ_en      (integ_en),
    .comb_en       (comb_en),
    .filt_clr      (filt_clr),
    .out_shift     (out_shift),
    .ovf_in        (ovf_in),
    .ovf_clr       (ovf_clr),
    .ovf_sticky    (ovf_sticky),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Leave IDLE and walk through CLEAR into the first SETTLE cycle.
  task automatic start_run(input logic [2:0] cfg, input int shift_exp, input string tag);
    @(negedge clk);
    enable        = 1'b1;
    cfg_rate_log2 = cfg;
    bus.s_valid   = 1'b1;
    bus.m_ready   = 1'b1;
    #1;
    check({tag, "_idle_state"}, state, 0);
    check({tag, "_idle_clr"}, filt_clr, 0);
    check({tag, "_idle_integ"}, integ_en, 0);
    @(negedge clk); #1;
    check({tag, "_clr_state"}, state, 1);
    check({tag, "_clr_pulse"}, filt_clr, 1);
    check({tag, "_clr_sready"}, bus.s_ready, 0);
    @(negedge clk); #1;
    check({tag, "_settle_state"}, state, 2);
    check({tag, "_clr_gone"}, filt_clr, 0);
    check({tag, "_sready"}, bus.s_ready, 1);
    check({tag, "_shift"}, out_shift, shift_exp);
  endtask

  // Continuous input from the first SETTLE cycle: two discarded blocks,
  // then the first output one cycle after the third comb strobe.
  task automatic run_blocks(input int r, input string tag);
    int n;
    n = 1 << r;
    for (int i = 0; i <= 3 * n; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      check($sformatf("%s_comb_%0d", tag, i), comb_en, ((i % n) == n - 1) ? 1 : 0);
      check($sformatf("%s_mvalid_%0d", tag, i), bus.m_valid, (i == 3 * n) ? 1 : 0);
      check($sformatf("%s_state_%0d", tag, i), state, (i < 2 * n) ? 2 : 3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    rstn          = 1'b0;
    enable        = 1'b0;
    cfg_rate_log2 = 3'd0;
    bus.s_valid   = 1'b0;
    bus.m_ready   = 1'b0;
    ovf_in        = 1'b0;
    ovf_clr       = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("por_state", state, 0);
    check("por_shift", out_shift, 2);
    check("por_mvalid", bus.m_valid, 0);
    check("por_sready", bus.s_ready, 0);
    check("por_ovf", ovf_sticky, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic run at rate 4.
    start_run(3'd2, 4, "basic");
    run_blocks(2, "basic");

    // Backpressure: hold the first output.
    bus.m_ready = 1'b0;
    @(negedge clk); #1;
    check("bp_mv_p1", bus.m_valid, 1);
    check("bp_sr_p1", bus.s_ready, 1);
    @(negedge clk); #1;
    check("bp_mv_p2", bus.m_valid, 1);
    check("bp_sr_p2", bus.s_ready, 1);
    @(negedge clk); #1;
    check("bp_mv_p3", bus.m_valid, 1);
    check("bp_sr_p3", bus.s_ready, 0);
    check("bp_integ_p3", integ_en, 0);
    check("bp_comb_p3", comb_en, 0);
    @(negedge clk); #1;
    check("bp_mv_hold", bus.m_valid, 1);
    check("bp_sr_hold", bus.s_ready, 0);
    bus.m_ready = 1'b1;
    #1;
    check("bp_no_passthru", bus.s_ready, 0);
    @(negedge clk); #1;
    check("bp_mv_taken", bus.m_valid, 0);
    check("bp_sr_back", bus.s_ready, 1);
    check("bp_comb_back", comb_en, 1);
    @(negedge clk); #1;
    check("bp_mv_next", bus.m_valid, 1);

    // Overflow flag in RUN.
    @(negedge clk);
    ovf_in = 1'b1;
    #1;
    check("ovf_pre", ovf_sticky, 0);
    @(negedge clk);
    ovf_in = 1'b0;
    #1;
    check("ovf_set", ovf_sticky, 1);
    @(negedge clk);
    ovf_in  = 1'b1;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_in  = 1'b0;
    ovf_clr = 1'b0;
    #1;
    check("ovf_set_wins", ovf_sticky, 1);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #1;
    check("ovf_clr", ovf_sticky, 0);

    // Disable while an output is pending.
    k = 0;
    @(negedge clk); #1;
    while (!bus.m_valid && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    check("dis_wait_mvalid", bus.m_valid, 1);
    enable      = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk); #1;
    check("dis_state", state, 0);
    check("dis_mvalid", bus.m_valid, 0);
    check("dis_sready", bus.s_ready, 0);
    check("dis_integ", integ_en, 0);

    // Re-enable: full clear/settle again with the phase restarted.
    start_run(3'd2, 4, "reen");
    run_blocks(2, "reen");

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    ovf_in = 1'b1;
    @(negedge clk);
    ovf_in = 1'b0;
    #1;
    check("rst_pre_ovf", ovf_sticky, 1);
    check("rst_pre_shift", out_shift, 4);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_state", state, 0);
    check("rst_sready", bus.s_ready, 0);
    check("rst_mvalid", bus.m_valid, 0);
    check("rst_comb", comb_en, 0);
    check("rst_integ", integ_en, 0);
    check("rst_clr", filt_clr, 0);
    check("rst_ovf", ovf_sticky, 0);
    check("rst_shift", out_shift, 2);
    enable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Clamp low: rate 0 behaves as rate 1; mid-run cfg change ignored.
    start_run(3'd0, 2, "clamp0");
    cfg_rate_log2 = 3'd7;
    run_blocks(1, "clamp0");
    check("clamp0_shift_kept", out_shift, 2);
    enable = 1'b0;
    @(negedge clk); #1;
    check("clamp0_idle", state, 0);

    // Overflow input is ignored in IDLE.
    @(negedge clk);
    ovf_in = 1'b1;
    #1;
    check("idle_clr", filt_clr, 0);
    check("idle_integ", integ_en, 0);
    check("idle_comb", comb_en, 0);
    @(negedge clk);
    ovf_in = 1'b0;
    #1;
    check("idle_ovf", ovf_sticky, 0);

    // Clamp high: rate 7 behaves as rate 6.
    start_run(3'd7, 12, "clamp7");
    run_blocks(6, "clamp7");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
